// File: rtl/deser4_nibble.sv
// Purpose : assemble a qualified 1-bit serial stream into 4-bit words with frame realign (sync).
// Latency : word valid on out_data/out_vld the cycle after its 4th bit is sampled.
// Backpres: one-word output register; a word completing while FULL and !out_rdy is dropped (ovf pulse).
//
// Ports:
//   clk, rst            single clock, synchronous active-high reset
//   sin, sin_vld        serial bit and its qualifier
//   sync                frame realign strobe (restarts the partial word)
//   out_data, out_vld   registered word and its valid flag
//   out_rdy             consumer accept; handshake is out_vld && out_rdy
//   ovf                 one-cycle pulse when a completed word is dropped
//   bit_cnt             bits collected in the current partial word (0..3)
module deser4_nibble #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    input  logic       sin_vld,
    input  logic       sync,
    output logic [3:0] out_data,
    output logic       out_vld,
    input  logic       out_rdy,
    output logic       ovf,
    output logic [1:0] bit_cnt
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] shreg_q;
    logic [3:0] word;
    logic [1:0] wr_idx;
    logic [1:0] pos;
    logic       complete;
    logic       load;
    logic       drop;

    // ------------------------------------------------------------------
    // Collector datapath.
    // A sync with a valid bit restarts the word at index 0, so the write
    // index and the base word are both taken from the restart case then.
    // 'word' is the shift register after this cycle's write; when the 4th
    // bit arrives it is the complete word and is what the output loads.
    // ------------------------------------------------------------------
    always_comb begin
        wr_idx = sync ? 2'd0 : bit_cnt;
        pos    = MSB_FIRST ? (2'd3 - wr_idx) : wr_idx;
        word   = sync ? 4'h0 : shreg_q;
        word[pos] = sin;
    end

    // A sync cycle never completes a word, even when bit_cnt is 3.
    assign complete = sin_vld && !sync && (bit_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= 4'h0;
            bit_cnt <= 2'd0;
        end else if (sin_vld) begin
            shreg_q <= word;
            bit_cnt <= sync ? 2'd1 : (bit_cnt + 2'd1);
        end else if (sync) begin
            bit_cnt <= 2'd0;
        end
    end

    // ------------------------------------------------------------------
    // Output register control: EMPTY/FULL.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            EMPTY: begin
                if (complete) begin
                    load    = 1'b1;
                    state_d = FULL;
                end
            end
            FULL: begin
                if (complete && out_rdy) begin
                    // Old word leaves on this edge while the new one lands.
                    load    = 1'b1;
                    state_d = FULL;
                end else if (complete) begin
                    // Held word has priority; the new one is discarded.
                    drop    = 1'b1;
                    state_d = FULL;
                end else if (out_rdy) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            out_data <= 4'h0;
            ovf      <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf     <= drop;
            if (load) begin
                out_data <= word;
            end
        end
    end

    // out_vld comes straight from the state flop: no out_rdy combinational path.
    assign out_vld = (state_q == FULL);

endmodule

// File: tb/tb_deser4_nibble.sv
// Directed bench: two instances (LSB-first and MSB-first) share one stimulus
// stream; a scoreboard per instance holds expected words, popped by a monitor
// on every handshake, with inline checks for timing, ovf and reset behaviour.
module tb_deser4_nibble;

    logic       clk;
    logic       rst;
    logic       sin;
    logic       sin_vld;
    logic       sync;
    logic       out_rdy;
    logic [3:0] out_data0, out_data1;
    logic       out_vld0, out_vld1;
    logic       ovf0, ovf1;
    logic [1:0] bit_cnt0, bit_cnt1;

    int checks   = 0;
    int failures = 0;
    int ovf_cnt0 = 0;
    int ovf_cnt1 = 0;

    logic [3:0] q0[$];
    logic [3:0] q1[$];

    deser4_nibble #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld), .sync(sync),
        .out_data(out_data0), .out_vld(out_vld0), .out_rdy(out_rdy),
        .ovf(ovf0), .bit_cnt(bit_cnt0)
    );

    deser4_nibble #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst(rst), .sin(sin), .sin_vld(sin_vld), .sync(sync),
        .out_data(out_data1), .out_vld(out_vld1), .out_rdy(out_rdy),
        .ovf(ovf1), .bit_cnt(bit_cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        sin     = b;
        sin_vld = 1'b1;
        sync    = s;
        tick();
        sin_vld = 1'b0;
        sync    = 1'b0;
        sin     = 1'b0;
    endtask

    task automatic idle();
        sin_vld = 1'b0;
        sync    = 1'b0;
        tick();
    endtask

    // Monitor: on the falling edge, a presented word with out_rdy high will
    // be accepted at the next rising edge, so compare it against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_vld0 && out_rdy) begin
                if (q0.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL lsb_unexpected_word: got %0h expected none", out_data0);
                end else begin
                    chk("lsb_word", int'(out_data0), int'(q0.pop_front()));
                end
            end
            if (out_vld1 && out_rdy) begin
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL msb_unexpected_word: got %0h expected none", out_data1);
                end else begin
                    chk("msb_word", int'(out_data1), int'(q1.pop_front()));
                end
            end
            if (ovf0) ovf_cnt0++;
            if (ovf1) ovf_cnt1++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        sin     = 1'b0;
        sin_vld = 1'b0;
        sync    = 1'b0;
        out_rdy = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        chk("init_out_vld", int'(out_vld0), 0);
        chk("init_out_data", int'(out_data0), 0);
        chk("init_bit_cnt", int'(bit_cnt1), 0);
        chk("init_ovf", int'(ovf1), 0);

        // Single word 1,0,1,1 with out_rdy high: LSB-first D, MSB-first B.
        out_rdy = 1'b1;
        q0.push_back(4'hD);
        q1.push_back(4'hB);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("vld_before_4th", int'(out_vld0), 0);
        send_bit(1'b1, 1'b0);
        chk("single_vld", int'(out_vld0), 1);
        chk("single_lsb_data", int'(out_data0), 4'hD);
        chk("single_msb_data", int'(out_data1), 4'hB);
        idle();
        chk("single_vld_one_cycle", int'(out_vld0), 0);

        // Back-to-back: 1,0,1,1 then 0,1,0,1 continuous (MSB: B,5; LSB: D,A).
        q0.push_back(4'hD);
        q1.push_back(4'hB);
        q0.push_back(4'hA);
        q1.push_back(4'h5);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("b2b_first_vld", int'(out_vld1), 1);
        chk("b2b_first_data", int'(out_data1), 4'hB);
        send_bit(1'b0, 1'b0);
        chk("b2b_gap_vld", int'(out_vld1), 0);
        chk("b2b_no_dead_cycle_cnt", int'(bit_cnt1), 1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("b2b_second_vld", int'(out_vld1), 1);
        chk("b2b_second_data", int'(out_data1), 4'h5);
        chk("b2b_second_lsb", int'(out_data0), 4'hA);
        idle();

        // Backpressure: 1,1,0,0 (LSB 3 / MSB C) held, then 0,0,1,1 dropped.
        out_rdy = 1'b0;
        q0.push_back(4'h3);
        q1.push_back(4'hC);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("bp_held_vld", int'(out_vld0), 1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("bp_no_ovf_early", int'(ovf0), 0);
        send_bit(1'b1, 1'b0);
        chk("bp_ovf_pulse", int'(ovf0), 1);
        chk("bp_data_kept", int'(out_data0), 4'h3);
        chk("bp_data_kept_msb", int'(out_data1), 4'hC);
        chk("bp_still_vld", int'(out_vld0), 1);
        idle();
        chk("bp_ovf_one_cycle", int'(ovf0), 0);
        chk("bp_held_after_drop", int'(out_data0), 4'h3);
        out_rdy = 1'b1;
        idle();
        chk("bp_vld_falls", int'(out_vld0), 0);

        // Simultaneous consume and load: hold A (LSB bits 0,1,0,1), then 6.
        out_rdy = 1'b0;
        q0.push_back(4'hA);
        q1.push_back(4'h5);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        q0.push_back(4'h6);
        q1.push_back(4'h6);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("sim_held_a", int'(out_data0), 4'hA);
        out_rdy = 1'b1;
        send_bit(1'b0, 1'b0);
        chk("sim_vld_stays", int'(out_vld0), 1);
        chk("sim_data_6", int'(out_data0), 4'h6);
        chk("sim_no_ovf", int'(ovf0), 0);
        idle();
        chk("sim_drained", int'(out_vld0), 0);

        // Sync realign: 1,1 then sync with bit 1, then 0,0,1 -> 1,0,0,1 = 9.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("sync_pre_cnt", int'(bit_cnt0), 2);
        send_bit(1'b1, 1'b1);
        chk("sync_cnt_1", int'(bit_cnt0), 1);
        chk("sync_cnt_1_msb", int'(bit_cnt1), 1);
        q0.push_back(4'h9);
        q1.push_back(4'h9);
        send_bit(1'b0, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("sync_no_early_vld", int'(out_vld0), 0);
        send_bit(1'b1, 1'b0);
        chk("sync_word_lsb", int'(out_data0), 4'h9);
        chk("sync_word_msb", int'(out_data1), 4'h9);
        chk("sync_no_ovf", int'(ovf0), 0);
        idle();

        // Sync without a bit clears the partial count.
        send_bit(1'b1, 1'b0);
        sync = 1'b1;
        tick();
        sync = 1'b0;
        chk("sync_idle_cnt_0", int'(bit_cnt0), 0);

        // Reset mid-word with a held word: both are lost.
        out_rdy = 1'b0;
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("rst_pre_cnt", int'(bit_cnt0), 2);
        chk("rst_pre_vld", int'(out_vld0), 1);
        rst     = 1'b1;
        sin_vld = 1'b1;
        sin     = 1'b1;
        out_rdy = 1'b1;
        tick();
        tick();
        rst     = 1'b0;
        sin_vld = 1'b0;
        sin     = 1'b0;
        chk("rst_out_vld", int'(out_vld0), 0);
        chk("rst_out_data", int'(out_data0), 0);
        chk("rst_out_data_msb", int'(out_data1), 0);
        chk("rst_bit_cnt", int'(bit_cnt0), 0);
        chk("rst_ovf", int'(ovf0), 0);

        // Fresh word after reset: 1,1,1,0 -> LSB 7, MSB E.
        q0.push_back(4'h7);
        q1.push_back(4'hE);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        chk("fresh_lsb", int'(out_data0), 4'h7);
        chk("fresh_msb", int'(out_data1), 4'hE);
        idle();
        idle();

        chk("lsb_queue_empty", q0.size(), 0);
        chk("msb_queue_empty", q1.size(), 0);
        chk("lsb_ovf_total", ovf_cnt0, 1);
        chk("msb_ovf_total", ovf_cnt1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
